// File: rtl/dugum_listeleyici.sv
// Level-to-node reverse lookup: streams every node ID on a requested level in
// ascending order over a valid/ready handshake, then pulses done with the count.
module dugum_listeleyici (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_istek_gecerli,
    input  logic [2:0] i_istek_seviye,
    output logic       o_istek_hazir,
    output logic       o_dugum_gecerli,
    output logic [3:0] o_dugum,
    output logic       o_dugum_son,
    input  logic       i_dugum_hazir,
    output logic       o_bitti,
    output logic       o_bos,
    output logic [4:0] o_adet
);

    localparam int unsigned DUGUM_W  = 4;
    localparam int unsigned SEVIYE_W = 3;
    localparam int unsigned MASKE_W  = 16;
    localparam int unsigned ADET_W   = 5;

    typedef enum logic [1:0] {BOSTA, GONDER, BITTI} durum_t;

    // Fixed node-level map, expressed as one node mask per level.
    function automatic logic [MASKE_W-1:0] seviye_maskesi(input logic [SEVIYE_W-1:0] s);
        logic [MASKE_W-1:0] m;
        case (s)
            3'd0:    m = 16'h0041;
            3'd1:    m = 16'h0002;
            3'd2:    m = 16'h0038;
            3'd3:    m = 16'h3F84;
            3'd4:    m = 16'hC000;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    function automatic logic [DUGUM_W-1:0] en_dusuk(input logic [MASKE_W-1:0] m);
        logic [DUGUM_W-1:0] r;
        r = '0;
        for (int i = MASKE_W - 1; i >= 0; i--) begin
            if (m[i]) r = DUGUM_W'(i);
        end
        return r;
    endfunction

    function automatic logic tek_bit(input logic [MASKE_W-1:0] m);
        return (m != '0) && ((m & (m - MASKE_W'(1))) == '0);
    endfunction

    durum_t              r_durum;
    logic [MASKE_W-1:0]  r_maske;
    logic [ADET_W-1:0]   r_sayac;
    logic                r_dugum_gecerli;
    logic [DUGUM_W-1:0]  r_dugum;
    logic                r_dugum_son;
    logic                r_bitti;
    logic                r_bos;
    logic [ADET_W-1:0]   r_adet;

    logic [MASKE_W-1:0]  w_yeni_maske;
    logic [MASKE_W-1:0]  w_kalan;
    logic [ADET_W-1:0]   w_sayac_art;

    assign w_yeni_maske = seviye_maskesi(i_istek_seviye);
    assign w_kalan      = r_maske & (r_maske - MASKE_W'(1));
    assign w_sayac_art  = r_sayac + ADET_W'(1);

    // Ready is a pure state decode, gated by reset so it drops while rst is held.
    assign o_istek_hazir   = (r_durum == BOSTA) && !rst;
    assign o_dugum_gecerli = r_dugum_gecerli;
    assign o_dugum         = r_dugum;
    assign o_dugum_son     = r_dugum_son;
    assign o_bitti         = r_bitti;
    assign o_bos           = r_bos;
    assign o_adet          = r_adet;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_durum         <= BOSTA;
            r_maske         <= '0;
            r_sayac         <= '0;
            r_dugum_gecerli <= 1'b0;
            r_dugum         <= '0;
            r_dugum_son     <= 1'b0;
            r_bitti         <= 1'b0;
            r_bos           <= 1'b0;
            r_adet          <= '0;
        end else begin
            case (r_durum)
                BOSTA: begin
                    r_bitti <= 1'b0;
                    r_bos   <= 1'b0;
                    r_adet  <= '0;
                    if (i_istek_gecerli) begin
                        r_maske <= w_yeni_maske;
                        r_sayac <= '0;
                        if (w_yeni_maske != '0) begin
                            r_durum         <= GONDER;
                            r_dugum_gecerli <= 1'b1;
                            r_dugum         <= en_dusuk(w_yeni_maske);
                            r_dugum_son     <= tek_bit(w_yeni_maske);
                        end else begin
                            r_durum <= BITTI;
                            r_bitti <= 1'b1;
                            r_bos   <= 1'b1;
                        end
                    end
                end
                GONDER: begin
                    // Outputs are loaded for the next ID, so they hold while the consumer stalls.
                    if (i_dugum_hazir) begin
                        r_maske <= w_kalan;
                        r_sayac <= w_sayac_art;
                        if (r_dugum_son) begin
                            r_durum         <= BITTI;
                            r_dugum_gecerli <= 1'b0;
                            r_dugum         <= '0;
                            r_dugum_son     <= 1'b0;
                            r_bitti         <= 1'b1;
                            r_adet          <= w_sayac_art;
                        end else begin
                            r_dugum     <= en_dusuk(w_kalan);
                            r_dugum_son <= tek_bit(w_kalan);
                        end
                    end
                end
                BITTI: begin
                    r_durum <= BOSTA;
                    r_bitti <= 1'b0;
                    r_bos   <= 1'b0;
                    r_adet  <= '0;
                end
                default: begin
                    r_durum <= BOSTA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dugum_listeleyici.sv
// Directed bench for dugum_listeleyici: hand-computed output vectors per cycle.
module tb_dugum_listeleyici;

    logic       clk = 1'b0;
    logic       rst;
    logic       istek_gecerli;
    logic [2:0] istek_seviye;
    logic       istek_hazir;
    logic       dugum_gecerli;
    logic [3:0] dugum;
    logic       dugum_son;
    logic       dugum_hazir;
    logic       bitti;
    logic       bos;
    logic [4:0] adet;

    int n_test = 0;
    int n_fail = 0;

    dugum_listeleyici dut (
        .clk             (clk),
        .rst             (rst),
        .i_istek_gecerli (istek_gecerli),
        .i_istek_seviye  (istek_seviye),
        .o_istek_hazir   (istek_hazir),
        .o_dugum_gecerli (dugum_gecerli),
        .o_dugum         (dugum),
        .o_dugum_son     (dugum_son),
        .i_dugum_hazir   (dugum_hazir),
        .o_bitti         (bitti),
        .o_bos           (bos),
        .o_adet          (adet)
    );

    always #5 clk = ~clk;

    // Packed view of all outputs: {hazir, gecerli, dugum[3:0], son, bitti, bos, adet[4:0]}
    function automatic logic [13:0] ciktilar();
        return {istek_hazir, dugum_gecerli, dugum, dugum_son, bitti, bos, adet};
    endfunction

    function automatic logic [13:0] bek(input logic h, input logic g, input logic [3:0] d,
                                        input logic s, input logic b, input logic e,
                                        input logic [4:0] a);
        return {h, g, d, s, b, e, a};
    endfunction

    task automatic chk(input string tag, input logic [15:0] gozlenen, input logic [15:0] beklenen);
        n_test++;
        assert (gozlenen === beklenen)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, gozlenen, beklenen);
        end
    endtask

    task automatic adim();
        @(posedge clk);
        #1;
    endtask

    logic [13:0] BOSTA_V;
    logic [7:0]  l3_ids [8];
    logic [4:0]  sweep_adet [8];
    logic [15:0] gorulen;
    int          toplam;
    bit          bitti_goruldu;

    initial begin
        BOSTA_V    = bek(1, 0, 0, 0, 0, 0, 0);
        l3_ids     = '{8'd2, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13};
        sweep_adet = '{5'd2, 5'd1, 5'd3, 5'd8, 5'd2, 5'd0, 5'd0, 5'd0};

        rst = 1'b1; istek_gecerli = 1'b0; istek_seviye = 3'd0; dugum_hazir = 1'b0;
        adim(); adim();
        chk("reset_during", 16'(ciktilar()), 16'(bek(0, 0, 0, 0, 0, 0, 0)));
        rst = 1'b0;
        #1;
        chk("reset_after", 16'(ciktilar()), 16'(BOSTA_V));

        // Level 3 with consumer always ready
        istek_gecerli = 1'b1; istek_seviye = 3'd3; dugum_hazir = 1'b1;
        adim();
        istek_gecerli = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("l3_id", 16'(ciktilar()), 16'(bek(0, 1, 4'(l3_ids[k]), (k == 7), 0, 0, 0)));
            adim();
        end
        chk("l3_done", 16'(ciktilar()), 16'(bek(0, 0, 0, 0, 1, 0, 5'd8)));
        adim();
        chk("l3_idle", 16'(ciktilar()), 16'(BOSTA_V));

        // Level 0 with stalling consumer
        istek_gecerli = 1'b1; istek_seviye = 3'd0; dugum_hazir = 1'b0;
        adim();
        istek_gecerli = 1'b0; istek_seviye = 3'd3;
        chk("l0_id0", 16'(ciktilar()), 16'(bek(0, 1, 0, 0, 0, 0, 0)));
        adim();
        chk("l0_id0_hold", 16'(ciktilar()), 16'(bek(0, 1, 0, 0, 0, 0, 0)));
        dugum_hazir = 1'b1;
        adim();
        dugum_hazir = 1'b0;
        chk("l0_id6", 16'(ciktilar()), 16'(bek(0, 1, 4'd6, 1, 0, 0, 0)));
        adim();
        chk("l0_id6_hold", 16'(ciktilar()), 16'(bek(0, 1, 4'd6, 1, 0, 0, 0)));
        dugum_hazir = 1'b1;
        adim();
        dugum_hazir = 1'b0;
        chk("l0_done", 16'(ciktilar()), 16'(bek(0, 0, 0, 0, 1, 0, 5'd2)));
        adim();
        chk("l0_idle", 16'(ciktilar()), 16'(BOSTA_V));

        // Empty level 5
        istek_gecerli = 1'b1; istek_seviye = 3'd5; dugum_hazir = 1'b1;
        adim();
        istek_gecerli = 1'b0;
        chk("l5_done", 16'(ciktilar()), 16'(bek(0, 0, 0, 0, 1, 1, 0)));
        adim();
        chk("l5_idle", 16'(ciktilar()), 16'(BOSTA_V));

        // Level 4 aborted by reset after ID 14 handshake
        istek_gecerli = 1'b1; istek_seviye = 3'd4;
        adim();
        istek_gecerli = 1'b0;
        chk("l4_id14", 16'(ciktilar()), 16'(bek(0, 1, 4'd14, 0, 0, 0, 0)));
        adim();
        chk("l4_id15", 16'(ciktilar()), 16'(bek(0, 1, 4'd15, 1, 0, 0, 0)));
        rst = 1'b1;
        adim();
        chk("l4_rst", 16'(ciktilar()), 16'(bek(0, 0, 0, 0, 0, 0, 0)));
        rst = 1'b0;
        #1;
        chk("l4_rst_rel", 16'(ciktilar()), 16'(BOSTA_V));
        adim();
        chk("l4_no_bitti", 16'(ciktilar()), 16'(BOSTA_V));

        istek_gecerli = 1'b1; istek_seviye = 3'd1;
        adim();
        istek_gecerli = 1'b0;
        chk("l1_id1", 16'(ciktilar()), 16'(bek(0, 1, 4'd1, 1, 0, 0, 0)));
        adim();
        chk("l1_done", 16'(ciktilar()), 16'(bek(0, 0, 0, 0, 1, 0, 5'd1)));
        adim();
        chk("l1_idle", 16'(ciktilar()), 16'(BOSTA_V));

        // Level 2 with a competing request held during the stream
        istek_gecerli = 1'b1; istek_seviye = 3'd2;
        adim();
        istek_seviye = 3'd4;
        chk("l2_id3", 16'(ciktilar()), 16'(bek(0, 1, 4'd3, 0, 0, 0, 0)));
        adim();
        chk("l2_id4", 16'(ciktilar()), 16'(bek(0, 1, 4'd4, 0, 0, 0, 0)));
        adim();
        chk("l2_id5", 16'(ciktilar()), 16'(bek(0, 1, 4'd5, 1, 0, 0, 0)));
        adim();
        istek_gecerli = 1'b0;
        chk("l2_done", 16'(ciktilar()), 16'(bek(0, 0, 0, 0, 1, 0, 5'd3)));
        adim();
        chk("l2_idle", 16'(ciktilar()), 16'(BOSTA_V));

        // Sweep all levels back to back
        gorulen = '0;
        toplam  = 0;
        for (int l = 0; l < 8; l++) begin
            istek_gecerli = 1'b1; istek_seviye = 3'(l);
            adim();
            istek_gecerli = 1'b0;
            bitti_goruldu = 1'b0;
            for (int c = 0; c < 20 && !bitti_goruldu; c++) begin
                if (dugum_gecerli) begin
                    chk("sweep_unique", 16'(gorulen[dugum]), 16'd0);
                    gorulen[dugum] = 1'b1;
                    toplam++;
                end
                if (bitti) begin
                    bitti_goruldu = 1'b1;
                    chk("sweep_adet", 16'(adet), 16'(sweep_adet[l]));
                end else begin
                    adim();
                end
            end
            chk("sweep_timeout", 16'(bitti_goruldu), 16'd1);
            adim();
            chk("sweep_idle", 16'(ciktilar()), 16'(BOSTA_V));
        end
        chk("sweep_all_nodes", gorulen, 16'hFFFF);
        chk("sweep_total", 16'(toplam), 16'd16);

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule
